// File: rtl/sram_arb_ctrl_pkg.sv
// Shared types and constants for the two-requester async SRAM controller.
// Contents:
//   SRAM_AW / SRAM_DW  native address and data widths of the board SRAM
//   sram_state_t       access sequencer states
//   sram_req_t         one requester transaction (wr, addr, wdata, be)
//   pin_be_n()         maps requester byte enables to active-low pin levels
package sram_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } sram_state_t;

    typedef struct packed {
        logic               wr;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] wdata;
        logic [1:0]         be;
    } sram_req_t;

    // Reads always enable both lanes; writes follow the requester's enables.
    function automatic logic [1:0] pin_be_n(input logic wr, input logic [1:0] be);
        logic [1:0] res;
        if (wr) begin
            res = ~be;
        end else begin
            res = 2'b00;
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter.
// Ports:
//   clk_i, rst_ni, srst_i  clock, async active-low reset, sync soft reset
//   req_i[1:0]             request vector
//   adv_i                  a grant was taken this cycle; move the pointer
//   win_o[1:0]             one-hot winner (all zero when nobody requests)
// The pointer names the requester favoured on a tie; after a grant it
// points at the requester that did not win.
module sram_rr_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       srst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] win_o
);

    logic ptr_q;
    logic ptr_d;

    // Winner select: a lone requester wins outright, a tie goes to the pointer.
    always_comb begin
        win_o = 2'b00;
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = ptr_q ? 2'b10 : 2'b01;
            default: win_o = 2'b00;
        endcase
    end

    // Pointer next state: favour requester 1 exactly when requester 0 just won.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = win_o[0];
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else if (srst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Round-robin arbiter and access sequencer for a 256Kx16 asynchronous SRAM.
// Ports:
//   clk_i, reset_ni, srst_i      clock, async active-low reset, sync soft reset
//   req_i/wr_i/addr_i/wdata_i/be_i  per-requester request fields (index 0,1)
//   gnt_o[1:0]                   1-cycle accept pulse; fields sampled that cycle
//   rvalid_o[1:0], rdata_o       read-return pulse and shared read data
//   busy_o                       sequencer not idle
//   sram_*_o, sram_dq_io         registered SRAM pins and tri-state data bus
// A read keeps OE low for RD_CYC cycles and returns data RD_CYC+1 cycles after
// gnt. A write runs setup (1), WE pulse (WR_CYC), hold (1). Grants are blocked
// while rvalid pulses, so CE always goes high for at least one cycle between
// accesses and the data bus has a turnaround gap.
module sram_arb_ctrl
    import sram_pkg::*;
#(
    parameter int AW     = SRAM_AW,
    parameter int DW     = SRAM_DW,
    parameter int RD_CYC = 2,
    parameter int WR_CYC = 2
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                srst_i,
    input  logic [1:0]          req_i,
    input  logic [1:0]          wr_i,
    input  logic [1:0][AW-1:0]  addr_i,
    input  logic [1:0][DW-1:0]  wdata_i,
    input  logic [1:0][1:0]     be_i,
    output logic [1:0]          gnt_o,
    output logic [1:0]          rvalid_o,
    output logic [DW-1:0]       rdata_o,
    output logic                busy_o,
    output logic [AW-1:0]       sram_addr_o,
    inout  wire  [DW-1:0]       sram_dq_io,
    output logic                sram_ce_n_o,
    output logic                sram_oe_n_o,
    output logic                sram_we_n_o,
    output logic [1:0]          sram_be_n_o
);

    localparam int MAXC = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYC - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYC - 1);

    sram_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          win_idx_q, win_idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dq_out_q, dq_out_d;
    logic          dq_oe_q, dq_oe_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic [1:0]    be_n_q, be_n_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rvalid_q, rvalid_d;

    logic [1:0]    win_s;
    logic          win_idx_s;
    logic          grant_s;

    sram_rr_arb u_arb (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .srst_i (srst_i),
        .req_i  (req_i),
        .adv_i  (grant_s),
        .win_o  (win_s)
    );

    assign win_idx_s = win_s[1];
    // The rvalid cycle is an enforced gap: no grant while it pulses.
    assign grant_s   = (state_q == IDLE) && (rvalid_q == 2'b00) && (win_s != 2'b00);
    assign gnt_o     = grant_s ? win_s : 2'b00;

    assign busy_o      = (state_q != IDLE);
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign sram_addr_o = addr_q;
    assign sram_ce_n_o = ce_n_q;
    assign sram_oe_n_o = oe_n_q;
    assign sram_we_n_o = we_n_q;
    assign sram_be_n_o = be_n_q;
    assign sram_dq_io  = dq_oe_q ? dq_out_q : {DW{1'bz}};

    // Sequencer next state and next pin levels.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_idx_d = win_idx_q;
        addr_d    = addr_q;
        dq_out_d  = dq_out_q;
        dq_oe_d   = dq_oe_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        be_n_d    = be_n_q;
        rdata_d   = rdata_q;
        rvalid_d  = 2'b00;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    win_idx_d = win_idx_s;
                    addr_d    = addr_i[win_idx_s];
                    dq_out_d  = wdata_i[win_idx_s];
                    be_n_d    = pin_be_n(wr_i[win_idx_s], be_i[win_idx_s]);
                    ce_n_d    = 1'b0;
                    if (wr_i[win_idx_s]) begin
                        dq_oe_d = 1'b1;
                        oe_n_d  = 1'b1;
                        state_d = WR_SETUP;
                    end else begin
                        dq_oe_d = 1'b0;
                        oe_n_d  = 1'b0;
                        cnt_d   = RD_LOAD;
                        state_d = RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (cnt_q == {CW{1'b0}}) begin
                    rdata_d  = sram_dq_io;
                    rvalid_d = win_idx_q ? 2'b10 : 2'b01;
                    ce_n_d   = 1'b1;
                    oe_n_d   = 1'b1;
                    be_n_d   = 2'b11;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = WR_LOAD;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    we_n_d  = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WR_HOLD: begin
                dq_oe_d = 1'b0;
                ce_n_d  = 1'b1;
                be_n_d  = 2'b11;
                state_d = IDLE;
            end
            default: begin
                dq_oe_d = 1'b0;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                we_n_d  = 1'b1;
                be_n_d  = 2'b11;
                state_d = IDLE;
            end
        endcase
    end

    // State and pin registers; reset drops every pin to its idle level at once.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            win_idx_q <= 1'b0;
            addr_q    <= {AW{1'b0}};
            dq_out_q  <= {DW{1'b0}};
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= 2'b11;
            rdata_q   <= {DW{1'b0}};
            rvalid_q  <= 2'b00;
        end else if (srst_i) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            win_idx_q <= 1'b0;
            addr_q    <= {AW{1'b0}};
            dq_out_q  <= {DW{1'b0}};
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= 2'b11;
            rdata_q   <= {DW{1'b0}};
            rvalid_q  <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_idx_q <= win_idx_d;
            addr_q    <= addr_d;
            dq_out_q  <= dq_out_d;
            dq_oe_q   <= dq_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: a single driver feeds per-requester transaction
// queues, a behavioural byte-lane SRAM sits on the pins, and one monitor owns
// a reference memory, a round-robin model and the expected-read queues.
module tb_sram_arb_ctrl;
    import sram_pkg::*;

    localparam int RD_CYC = 2;
    localparam int WR_CYC = 2;
    localparam int AW = SRAM_AW;
    localparam int DW = SRAM_DW;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic                rst_n;
    logic                srst;
    logic [1:0]          req_v;
    logic [1:0]          wr_v;
    logic [1:0][AW-1:0]  addr_v;
    logic [1:0][DW-1:0]  wdata_v;
    logic [1:0][1:0]     be_v;
    logic [1:0]          gnt_s;
    logic [1:0]          rvalid_s;
    logic [DW-1:0]       rdata_s;
    logic                busy_s;
    logic [AW-1:0]       sram_addr;
    wire  [DW-1:0]       sram_dq;
    logic                ce_n, oe_n, we_n;
    logic [1:0]          be_n;

    sram_arb_ctrl #(.AW(AW), .DW(DW), .RD_CYC(RD_CYC), .WR_CYC(WR_CYC)) dut (
        .clk_i(clk), .reset_ni(rst_n), .srst_i(srst),
        .req_i(req_v), .wr_i(wr_v), .addr_i(addr_v), .wdata_i(wdata_v), .be_i(be_v),
        .gnt_o(gnt_s), .rvalid_o(rvalid_s), .rdata_o(rdata_s), .busy_o(busy_s),
        .sram_addr_o(sram_addr), .sram_dq_io(sram_dq),
        .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n), .sram_be_n_o(be_n)
    );

    // ---------------- behavioural asynchronous SRAM ----------------
    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : {DW{1'bz}};

    always @(negedge clk) begin
        if (rst_n && !ce_n && !we_n) begin
            if (!be_n[0]) mem[sram_addr][7:0]  <= sram_dq[7:0];
            if (!be_n[1]) mem[sram_addr][15:8] <= sram_dq[15:8];
        end
    end

    // ---------------- monitor / scoreboard ----------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic [31:0]   due;
    } exp_t;

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    exp_t          exp_q0[$];
    exp_t          exp_q1[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    bit            ptr_m = 1'b0;
    bit            drv_timeout = 1'b0;
    bit            to_seen = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wd = '0;
    logic [1:0]    cur_ben = 2'b11;
    bit            in_wr = 1'b0;
    int            win_len = 0;
    int            we_low = 0;
    int            rd_len = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return {DW{1'b0}};
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        bit          w;
        logic        wi;
        logic [1:0]  exp_g;
        logic [DW-1:0] m;
        if (!rst_n) begin
            chk("rst_gnt", 32'(gnt_s), 32'd0);
            chk("rst_rvalid", 32'(rvalid_s), 32'd0);
            chk("rst_rdata", 32'(rdata_s), 32'd0);
            chk("rst_busy", 32'(busy_s), 32'd0);
            chk("rst_addr", 32'(sram_addr), 32'd0);
            chk("rst_ce_n", 32'(ce_n), 32'd1);
            chk("rst_oe_n", 32'(oe_n), 32'd1);
            chk("rst_we_n", 32'(we_n), 32'd1);
            chk("rst_be_n", 32'(be_n), 32'd3);
            ptr_m = 1'b0;
            exp_q0.delete();
            exp_q1.delete();
            in_wr = 1'b0; win_len = 0; we_low = 0; rd_len = 0;
        end else begin
            // read returns
            if (rvalid_s[0]) begin
                if (exp_q0.size() == 0) chk("stray_rvalid0", 32'd1, 32'd0);
                else begin
                    e = exp_q0.pop_front();
                    chk("rdata0", 32'(rdata_s), 32'(e.d));
                    chk("rd_latency0", 32'(cyc), e.due);
                end
            end
            if (rvalid_s[1]) begin
                if (exp_q1.size() == 0) chk("stray_rvalid1", 32'd1, 32'd0);
                else begin
                    e = exp_q1.pop_front();
                    chk("rdata1", 32'(rdata_s), 32'(e.d));
                    chk("rd_latency1", 32'(cyc), e.due);
                end
            end
            // grants: round-robin model and reference memory
            if (gnt_s != 2'b00) begin
                if (req_v == 2'b11) w = ptr_m;
                else w = req_v[1];
                exp_g = w ? 2'b10 : 2'b01;
                chk("gnt_winner", 32'(gnt_s), 32'(exp_g));
                chk("gnt_without_req", 32'(gnt_s & ~req_v), 32'd0);
                chk("gnt_idle_gap", 32'(ce_n), 32'd1);
                ptr_m = !w;
                wi = gnt_s[1];
                cur_addr = addr_v[wi];
                if (wr_v[wi]) begin
                    m = {{8{be_v[wi][1]}}, {8{be_v[wi][0]}}};
                    ref_mem[addr_v[wi]] = (ref_rd(addr_v[wi]) & ~m) | (wdata_v[wi] & m);
                    cur_wd = wdata_v[wi];
                    cur_ben = ~be_v[wi];
                end else begin
                    e.d = ref_rd(addr_v[wi]);
                    e.due = 32'(cyc + RD_CYC + 1);
                    if (wi) exp_q1.push_back(e);
                    else exp_q0.push_back(e);
                    cur_ben = 2'b00;
                end
            end
            // write window: pins stable and WE pulse width
            if (!ce_n && oe_n) begin
                chk("wr_addr_stable", 32'(sram_addr), 32'(cur_addr));
                chk("wr_dq_stable", 32'(sram_dq), 32'(cur_wd));
                chk("wr_be_n", 32'(be_n), 32'(cur_ben));
                if (win_len == 0) chk("wr_setup_we_n", 32'(we_n), 32'd1);
                win_len++;
                if (!we_n) we_low++;
                in_wr = 1'b1;
            end else if (in_wr) begin
                chk("we_low_cycles", 32'(we_low), 32'(WR_CYC));
                chk("wr_window_cycles", 32'(win_len), 32'(WR_CYC + 2));
                in_wr = 1'b0; win_len = 0; we_low = 0;
            end
            // read window: OE never overlaps WE, both lanes enabled
            if (!ce_n && !oe_n) begin
                chk("rd_we_n", 32'(we_n), 32'd1);
                chk("rd_be_n", 32'(be_n), 32'd0);
                chk("rd_addr", 32'(sram_addr), 32'(cur_addr));
                rd_len++;
            end else if (rd_len > 0) begin
                chk("oe_low_cycles", 32'(rd_len), 32'(RD_CYC));
                rd_len = 0;
            end
        end
        if (drv_timeout && !to_seen) begin
            chk("drain_timeout", 32'd1, 32'd0);
            to_seen = 1'b1;
        end
        cyc++;
    end

    // ---------------- driver ----------------
    sram_req_t pend0[$];
    sram_req_t pend1[$];
    logic [1:0] act_v = 2'b00;
    bit         rand_dly = 1'b0;

    task automatic load(input int r, input sram_req_t t);
        req_v[r]   = 1'b1;
        wr_v[r]    = t.wr;
        addr_v[r]  = t.addr;
        wdata_v[r] = t.wdata;
        be_v[r]    = t.be;
        act_v[r]   = 1'b1;
    endtask

    task automatic step();
        logic [1:0] g;
        @(negedge clk);
        g = gnt_s;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            if (act_v[r] && g[r]) begin
                act_v[r] = 1'b0;
                req_v[r] = 1'b0;
            end
        end
        if (!act_v[0] && pend0.size() > 0 && (!rand_dly || $urandom_range(0, 3) != 0))
            load(0, pend0.pop_front());
        if (!act_v[1] && pend1.size() > 0 && (!rand_dly || $urandom_range(0, 3) != 0))
            load(1, pend1.pop_front());
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || act_v != 2'b00 ||
                exp_q0.size() > 0 || exp_q1.size() > 0 || busy_s) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) drv_timeout = 1'b1;
        repeat (2) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        act_v = 2'b00;
        req_v = 2'b00;
        pend0.delete();
        pend1.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic sram_req_t mk(input logic w, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input logic [1:0] b);
        sram_req_t t;
        t.wr = w; t.addr = a; t.wdata = d; t.be = b;
        return t;
    endfunction

    logic [AW-1:0] ra [8];

    initial begin
        int n;
        rst_n = 1'b1; srst = 1'b0;
        req_v = '0; wr_v = '0; addr_v = '0; wdata_v = '0; be_v = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // single write then read
        pend0.push_back(mk(1'b1, 18'h00010, 16'hBEEF, 2'b11));
        drain(50);
        pend0.push_back(mk(1'b0, 18'h00010, 16'h0000, 2'b00));
        drain(50);

        // byte lanes: expect 0xAB34
        pend0.push_back(mk(1'b1, 18'h00020, 16'h1234, 2'b11));
        pend0.push_back(mk(1'b1, 18'h00020, 16'hAB00, 2'b10));
        pend0.push_back(mk(1'b0, 18'h00020, 16'h0000, 2'b11));
        drain(80);

        // address extremes
        pend0.push_back(mk(1'b1, 18'h3FFFF, 16'hA5A5, 2'b11));
        pend1.push_back(mk(1'b1, 18'h00000, 16'h5A5A, 2'b11));
        pend0.push_back(mk(1'b0, 18'h3FFFF, 16'h0000, 2'b11));
        pend1.push_back(mk(1'b0, 18'h00000, 16'h0000, 2'b11));
        drain(100);

        // back-to-back write then read, including a write with no lanes enabled
        pend0.push_back(mk(1'b1, 18'h00030, 16'hC0DE, 2'b11));
        pend0.push_back(mk(1'b0, 18'h00030, 16'h0000, 2'b11));
        pend1.push_back(mk(1'b1, 18'h00030, 16'hFFFF, 2'b00));
        pend1.push_back(mk(1'b0, 18'h00030, 16'h0000, 2'b11));
        drain(100);

        // contention right after reset: grants start at 0 and alternate
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pend0.push_back(mk(1'b0, 18'h00010, 16'h0000, 2'b11));
            pend1.push_back(mk(1'b0, 18'h00020, 16'h0000, 2'b11));
        end
        drain(150);

        // reset during the WE pulse, then a fresh access
        pend0.push_back(mk(1'b1, 18'h00040, 16'h7777, 2'b11));
        n = 0;
        while (we_n && n < 30) begin
            step();
            n++;
        end
        if (n >= 30) drv_timeout = 1'b1;
        do_reset();
        pend0.push_back(mk(1'b1, 18'h00041, 16'h1357, 2'b11));
        pend1.push_back(mk(1'b0, 18'h00041, 16'h0000, 2'b11));
        drain(80);

        // randomized mix over a small initialized address set
        rand_dly = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra[i] = AW'($urandom_range(32'h100, 32'h3FFFF));
            if (i % 2 == 0) pend0.push_back(mk(1'b1, ra[i], 16'($urandom), 2'b11));
            else pend1.push_back(mk(1'b1, ra[i], 16'($urandom), 2'b11));
        end
        drain(300);
        for (int i = 0; i < 40; i++) begin
            sram_req_t t;
            t = mk(1'($urandom_range(0, 1)), ra[$urandom_range(0, 7)],
                   16'($urandom), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) pend0.push_back(t);
            else pend1.push_back(t);
        end
        drain(1500);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
